// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: request/result and divider handshake signals of the modular exponentiation sequencer
interface mod_exp_ctrl_if #(parameter int EXP_W = 16);
  logic             start;
  logic [7:0]       base;
  logic [EXP_W-1:0] exponent;
  logic [7:0]       modulus;
  logic             busy;
  logic             done;
  logic [7:0]       result;
  logic             error;
  logic             div_start;
  logic [15:0]      div_dividend;
  logic [15:0]      div_divisor;
  logic [15:0]      div_quotient;
  logic [15:0]      div_remainder;
  logic             div_ready;
  modport master (
    output start, base, exponent, modulus, div_quotient, div_remainder, div_ready,
    input  busy, done, result, error, div_start, div_dividend, div_divisor
  );
  modport slave (
    input  start, base, exponent, modulus, div_quotient, div_remainder, div_ready,
    output busy, done, result, error, div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: right-to-left square-and-multiply base^exponent mod modulus using an external serial divider
module mod_exp_ctrl #(
  parameter int EXP_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_exp_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RED_B, CHECK, MUL, SQR, ISSUE, WAIT, FIN} state_t;
  state_t           r_state;
  state_t           r_ret;
  logic [7:0]       r_b;
  logic [7:0]       r_acc;
  logic [7:0]       r_p;
  logic [7:0]       r_result;
  logic [EXP_W-1:0] r_e;
  logic             r_tgt_acc;
  logic             r_skip;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             r_div_start;
  logic [15:0]      r_dividend;
  logic [EXP_W-1:0] w_e_next;
  logic [15:0]      w_prod_mul;
  logic [15:0]      w_prod_sqr;
  logic             w_unused;
  assign w_e_next   = r_e >> 1;
  assign w_prod_mul = 16'(r_acc) * 16'(r_b);
  assign w_prod_sqr = 16'(r_b) * 16'(r_b);
  assign w_unused   = ^{bus.div_quotient, bus.div_remainder[15:8]};
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.error        = r_error;
  assign bus.div_start    = r_div_start;
  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = {8'd0, r_p};
  // Sequencer: each reduction detours through ISSUE/WAIT and resumes at r_ret with the remainder in acc or b
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= 8'd0;
      r_error     <= 1'b0;
      r_div_start <= 1'b0;
      r_dividend  <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_b      <= bus.base;
          r_e      <= bus.exponent;
          r_p      <= bus.modulus;
          r_acc    <= 8'd1;
          r_result <= 8'd0;
          r_error  <= (bus.modulus == 8'd0);
          if (bus.modulus <= 8'd1) begin
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_busy  <= 1'b1;
            r_state <= RED_B;
          end
        end
        RED_B: begin
          r_dividend  <= {8'd0, r_b};
          r_tgt_acc   <= 1'b0;
          r_ret       <= CHECK;
          r_div_start <= 1'b1;
          r_state     <= ISSUE;
        end
        CHECK: if (r_e == '0) begin
          r_result <= r_acc;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= FIN;
        end else begin
          r_state <= r_e[0] ? MUL : SQR;
        end
        MUL: begin
          r_dividend  <= w_prod_mul;
          r_tgt_acc   <= 1'b1;
          r_ret       <= SQR;
          r_div_start <= 1'b1;
          r_state     <= ISSUE;
        end
        SQR: begin
          r_e <= w_e_next;
          if (w_e_next == '0) begin
            r_state <= CHECK;
          end else begin
            r_dividend  <= w_prod_sqr;
            r_tgt_acc   <= 1'b0;
            r_ret       <= CHECK;
            r_div_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: if (bus.div_ready) begin
          r_div_start <= 1'b0;
          r_skip      <= 1'b1;
          r_state     <= WAIT;
        end
        WAIT: if (r_skip) begin
          r_skip <= 1'b0;
        end else if (bus.div_ready) begin
          if (r_tgt_acc) r_acc <= bus.div_remainder[7:0];
          else r_b <= bus.div_remainder[7:0];
          r_state <= r_ret;
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: directed vectors against a behavioural 16-cycle divider, scoreboard-checked on done
module tb_mod_exp_ctrl;
  localparam int EXP_W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mod_exp_ctrl_if #(.EXP_W(EXP_W)) bus();
  mod_exp_ctrl #(.EXP_W(EXP_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int ndone = 0;
  int d0 = 0;
  int acc_n = 0;
  int starts = 0;
  int held = 0;
  int viol = 0;
  int extra = 0;
  logic [8:0] sb[$];
  logic        rdy = 1'b1;
  logic [15:0] rem = 16'd0;
  logic [15:0] rem_n = 16'd0;
  int          cnt = 0;
  logic        pend = 1'b0;
  assign bus.div_ready     = rdy;
  assign bus.div_remainder = rem;
  assign bus.div_quotient  = 16'd0;
  // Divider model: accepts on start&ready, ready low for 16 cycles (+extra), remainder presented on return
  always @(posedge clk) begin
    if (pend && !bus.div_start) viol++;
    pend = bus.div_start && !rdy;
    if (bus.div_start) starts++;
    if (bus.div_start && !rdy) held++;
    if (bus.div_start && rdy) begin
      acc_n++;
      rdy   <= 1'b0;
      cnt   <= 15 + extra;
      rem_n <= (bus.div_divisor == 16'd0) ? 16'd0 : bus.div_dividend % bus.div_divisor;
    end else if (!rdy) begin
      if (cnt == 0) begin
        rdy <= 1'b1;
        rem <= rem_n;
      end else cnt <= cnt - 1;
    end
  end
  // Monitor: every done pulse pops one expected {error,result}
  always @(negedge clk) begin
    if (bus.done) begin
      ndone++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got result=%0d error=%0d, required no done", bus.result, bus.error);
      end else begin
        logic [8:0] ev;
        ev = sb.pop_front();
        if ({bus.error, bus.result} !== ev) begin
          errors++;
          $display("FAIL done_value: got result=%0d error=%0d, required result=%0d error=%0d",
                   bus.result, bus.error, ev[7:0], ev[8]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask
  task automatic issue(input logic [7:0] b, input logic [15:0] e, input logic [7:0] m, input logic [8:0] ev);
    @(negedge clk);
    d0 = ndone;
    bus.base = b;
    bus.exponent = e;
    bus.modulus = m;
    bus.start = 1'b1;
    sb.push_back(ev);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int max, output int c);
    c = 0;
    #1;
    while (ndone == d0 && c < max) begin
      @(negedge clk);
      #1;
      c++;
    end
    checks++;
    if (ndone == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, max);
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end
  initial begin
    int c;
    int a0;
    int s0;
    bus.start = 1'b0;
    bus.base = 8'd0;
    bus.exponent = '0;
    bus.modulus = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.error, bus.div_start, bus.div_dividend}, 0);
    rst_n = 1'b1;
    a0 = acc_n;
    issue(8'd3, 16'd5, 8'd7, {1'b0, 8'd5});
    chk("busy_after_accept", bus.busy, 1);
    wait_done("pow_3_5_7", 700, c);
    chk("busy_low_at_done", bus.busy, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("accepts_3_5_7", acc_n - a0, 5);
    issue(8'd2, 16'd10, 8'd255, {1'b0, 8'd4});
    wait_done("pow_2_10_255", 700, c);
    issue(8'd200, 16'd3, 8'd11, {1'b0, 8'd8});
    wait_done("pow_200_3_11", 700, c);
    a0 = acc_n;
    issue(8'd5, 16'd0, 8'd13, {1'b0, 8'd1});
    wait_done("exp_zero", 700, c);
    chk("accepts_exp_zero", acc_n - a0, 1);
    s0 = starts;
    issue(8'd9, 16'd7, 8'd1, {1'b0, 8'd0});
    wait_done("mod_one", 700, c);
    chk("mod_one_no_div_start", starts - s0, 0);
    s0 = starts;
    issue(8'd9, 16'd7, 8'd0, {1'b1, 8'd0});
    wait_done("mod_zero", 700, c);
    chk("mod_zero_latency_le3", c <= 3, 1);
    chk("mod_zero_no_div_start", starts - s0, 0);
    issue(8'd3, 16'd5, 8'd7, {1'b0, 8'd5});
    repeat (10) @(negedge clk);
    bus.base = 8'd9;
    bus.exponent = 16'd3;
    bus.modulus = 8'd11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_while_busy", 700, c);
    repeat (5) @(negedge clk);
    chk("start_while_busy_one_done", ndone - d0, 1);
    chk("start_while_busy_queue_empty", sb.size(), 0);
    extra = 5;
    viol = 0;
    issue(8'd3, 16'd5, 8'd7, {1'b0, 8'd5});
    wait_done("slow_divider", 900, c);
    chk("slow_divider_start_held", viol, 0);
    extra = 0;
    repeat (30) @(negedge clk);
    a0 = acc_n;
    issue(8'd3, 16'd5, 8'd7, {1'b0, 8'd5});
    c = 0;
    while (acc_n < a0 + 2 && c < 200) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("mul_reached", acc_n >= a0 + 2, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {bus.busy, bus.done, bus.result, bus.error, bus.div_start, bus.div_dividend}, 0);
    chk("abort_no_done", ndone - d0, 0);
    rst_n = 1'b1;
    sb.delete();
    held = 0;
    viol = 0;
    issue(8'd7, 16'd255, 8'd251, {1'b0, 8'd241});
    wait_done("pow_7_255_251", 700, c);
    chk("resync_start_held_while_busy", held > 0, 1);
    chk("resync_no_early_drop", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
